// File: rtl/pll_ce_gen_if.sv
// Bus bundle for pll_ce_gen: increment programming, phase sync and enable/status outputs.
// loss_count is carried only when PLL_CE_LOSS_COUNT_EN is defined.
interface pll_ce_gen_if #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
);
  logic [NUM_CH*ACC_W-1:0] inc;
  logic                    inc_load;
  logic                    sync;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       ce_toggle;
  logic                    ready;
  logic                    lock_lost;

  if (NUM_CH < 1 || NUM_CH > 8 || ACC_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("pll_ce_gen_if: parameter out of range");
  end

`ifdef PLL_CE_LOSS_COUNT_EN
  logic [CNT_W-1:0] loss_count;

  modport master (output inc, inc_load, sync,
                  input  ce, ce_toggle, ready, lock_lost, loss_count);
  modport slave  (input  inc, inc_load, sync,
                  output ce, ce_toggle, ready, lock_lost, loss_count);
`else
  modport master (output inc, inc_load, sync,
                  input  ce, ce_toggle, ready, lock_lost);
  modport slave  (input  inc, inc_load, sync,
                  output ce, ce_toggle, ready, lock_lost);
`endif
endinterface

// File: rtl/pll_ce_gen.sv
// Lock-qualified multi-channel fractional clock-enable generator (phase accumulators).
// Optional lock-loss event counter enabled by PLL_CE_LOSS_COUNT_EN.
module pll_ce_gen #(
  parameter int NUM_CH    = 2,
  parameter int ACC_W     = 32,
  parameter int LOCK_FILT = 1024,
  parameter int CNT_W     = 8
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        pll_locked,
  pll_ce_gen_if.slave bus
);
  localparam int FC_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(LOCK_FILT - 1);

  if (NUM_CH < 1 || NUM_CH > 8 || ACC_W < 1 || LOCK_FILT < 1 || CNT_W < 1) begin : g_bad_param
    $error("pll_ce_gen: parameter out of range");
  end

  typedef enum logic [1:0] {WAIT_LOCK, FILTER, RUN} state_t;

  state_t            r_state;
  logic [FC_W-1:0]   r_fcnt;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_ready;
  logic              r_lock_lost;
  logic              w_lock_s;
  logic              w_run_stay;
  logic [NUM_CH-1:0] w_ce;
  logic [NUM_CH-1:0] w_tgl;
`ifdef PLL_CE_LOSS_COUNT_EN
  logic [CNT_W-1:0]  r_loss_cnt;
`endif

  assign w_lock_s = r_sync2;
  // Accumulate only on edges where RUN is both current and next, so ce drops with ready.
  assign w_run_stay = (r_state == RUN) && w_lock_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_state     <= WAIT_LOCK;
      r_fcnt      <= '0;
      r_ready     <= 1'b0;
      r_lock_lost <= 1'b0;
`ifdef PLL_CE_LOSS_COUNT_EN
      r_loss_cnt  <= '0;
`endif
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
      case (r_state)
        WAIT_LOCK: begin
          r_fcnt <= '0;
          if (w_lock_s) r_state <= FILTER;
        end
        FILTER: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_fcnt  <= '0;
          end else if (r_fcnt == FC_LAST) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        RUN: begin
          if (!w_lock_s) begin
            r_state     <= WAIT_LOCK;
            r_fcnt      <= '0;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b1;
`ifdef PLL_CE_LOSS_COUNT_EN
            if (r_loss_cnt != {CNT_W{1'b1}}) r_loss_cnt <= r_loss_cnt + 1'b1;
`endif
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          r_fcnt  <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] r_inc_act;
    logic [ACC_W-1:0] r_acc;
    logic             r_ce;
    logic             r_tgl;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc_act};

    always_ff @(posedge refclk) begin
      if (rst) begin
        r_inc_act <= '0;
        r_acc     <= '0;
        r_ce      <= 1'b0;
        r_tgl     <= 1'b0;
      end else begin
        if (bus.inc_load) r_inc_act <= bus.inc[i*ACC_W +: ACC_W];
        // Carry out of the add is the enable; the remainder stays in acc, so no drift.
        if (w_run_stay && !bus.sync) begin
          r_acc <= w_sum[ACC_W-1:0];
          r_ce  <= w_sum[ACC_W];
          r_tgl <= r_tgl ^ w_sum[ACC_W];
        end else begin
          r_acc <= '0;
          r_ce  <= 1'b0;
        end
      end
    end

    assign w_ce[i]  = r_ce;
    assign w_tgl[i] = r_tgl;
  end

  assign bus.ce        = w_ce;
  assign bus.ce_toggle = w_tgl;
  assign bus.ready     = r_ready;
  assign bus.lock_lost = r_lock_lost;
`ifdef PLL_CE_LOSS_COUNT_EN
  assign bus.loss_count = r_loss_cnt;
`endif
endmodule

// File: tb/tb_pll_ce_gen.sv
// Self-checking bench for pll_ce_gen; reference ce computed as floor(k*inc/2^ACC_W) differences.
// Define PLL_CE_LOSS_COUNT_EN to also exercise the lock-loss counter.
module tb_pll_ce_gen;
  localparam int NUM_CH    = 2;
  localparam int ACC_W     = 32;
  localparam int LOCK_FILT = 16;
  localparam int CNT_W     = 2;

  logic refclk = 1'b0;
  logic rst;
  logic pll_locked;

  always #5 refclk = ~refclk;

  pll_ce_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  pll_ce_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_FILT(LOCK_FILT), .CNT_W(CNT_W)) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: increments in force, accumulate steps since phase zero, toggle state.
  longint unsigned   m_inc [NUM_CH];
  longint unsigned   m_k;
  logic [NUM_CH-1:0] m_tgl;
  int                m_ce_cnt0;

  function automatic logic ce_at(longint unsigned inc, longint unsigned k);
    return ((k * inc) >> ACC_W) != (((k - 1) * inc) >> ACC_W);
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    pll_locked   = 1'b0;
    bus.inc      = '0;
    bus.inc_load = 1'b0;
    bus.sync     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) m_inc[c] = 0;
    m_k   = 0;
    m_tgl = '0;
  endtask

  task automatic load_inc(input longint unsigned a, input longint unsigned b);
    bus.inc      = {b[ACC_W-1:0], a[ACC_W-1:0]};
    bus.inc_load = 1'b1;
    tick();
    bus.inc_load = 1'b0;
    m_inc[0] = a;
    m_inc[1] = b;
  endtask

  // Raise lock from WAIT_LOCK with lock_s low; ready must appear exactly LOCK_FILT+2 edges later.
  task automatic go_run();
    logic exp_rdy;
    pll_locked = 1'b1;
    for (int n = 0; n <= LOCK_FILT + 2; n++) begin
      tick();
      exp_rdy = (n >= LOCK_FILT + 2);
      checks++;
      if (bus.ready !== exp_rdy) begin
        errors++;
        $display("FAIL go_run ready edge %0d: got %b expected %b", n, bus.ready, exp_rdy);
      end
      checks++;
      if (bus.ce !== '0 || bus.ce_toggle !== m_tgl) begin
        errors++;
        $display("FAIL go_run ce/tgl edge %0d: got %b/%b expected 00/%b", n, bus.ce, bus.ce_toggle, m_tgl);
      end
    end
    m_k = 0;
  endtask

  task automatic run_check(input int n);
    logic [NUM_CH-1:0] exp_ce;
    for (int j = 0; j < n; j++) begin
      tick();
      m_k++;
      for (int c = 0; c < NUM_CH; c++) begin
        exp_ce[c] = ce_at(m_inc[c], m_k);
        if (exp_ce[c]) m_tgl[c] = ~m_tgl[c];
      end
      if (exp_ce[0]) m_ce_cnt0++;
      checks++;
      if (bus.ce !== exp_ce || bus.ce_toggle !== m_tgl || bus.ready !== 1'b1) begin
        errors++;
        $display("FAIL run step %0d: got ce=%b tgl=%b rdy=%b expected ce=%b tgl=%b rdy=1",
                 m_k, bus.ce, bus.ce_toggle, bus.ready, exp_ce, m_tgl);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.ce !== '0 || bus.ce_toggle !== '0 || bus.ready !== 1'b0 || bus.lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got ce=%b tgl=%b rdy=%b lost=%b expected all 0",
               bus.ce, bus.ce_toggle, bus.ready, bus.lock_lost);
    end
  endtask

  task automatic test_lock_timing();
    do_reset();
    go_run();
    checks++;
    if (bus.lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL lock_timing lock_lost: got %b expected 0", bus.lock_lost);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    pll_locked = 1'b1;
    for (int n = 0; n < 9; n++) tick();
    pll_locked = 1'b0;
    tick();
    // One low sample must send FILTER back to WAIT_LOCK and restart the full filter.
    go_run();
  endtask

  task automatic test_rates();
    do_reset();
    load_inc(64'h8000_0000, 64'h4000_0000);
    go_run();
    run_check(40);
  endtask

  task automatic test_boundary();
    do_reset();
    load_inc(64'h0, 64'hFFFF_FFFF);
    go_run();
    run_check(24);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      load_inc(longint'($urandom), longint'($urandom));
      go_run();
      run_check(300);
    end
  endtask

  task automatic test_sync_load();
    longint unsigned na;
    longint unsigned nb;
    do_reset();
    load_inc(64'h5555_5555, longint'($urandom));
    go_run();
    run_check(37);
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    m_k = 0;
    checks++;
    if (bus.ce !== '0 || bus.ce_toggle !== m_tgl) begin
      errors++;
      $display("FAIL sync clear: got ce=%b tgl=%b expected ce=00 tgl=%b", bus.ce, bus.ce_toggle, m_tgl);
    end
    m_ce_cnt0 = 0;
    run_check(3 * 1024);
    checks++;
    if (m_ce_cnt0 < 1023 || m_ce_cnt0 > 1025) begin
      errors++;
      $display("FAIL sync rate count: got %0d expected 1024 +-1", m_ce_cnt0);
    end
    na = longint'($urandom);
    nb = longint'($urandom);
    bus.inc      = {nb[ACC_W-1:0], na[ACC_W-1:0]};
    bus.inc_load = 1'b1;
    bus.sync     = 1'b1;
    tick();
    bus.inc_load = 1'b0;
    bus.sync     = 1'b0;
    m_inc[0] = na;
    m_inc[1] = nb;
    m_k = 0;
    checks++;
    if (bus.ce !== '0) begin
      errors++;
      $display("FAIL load+sync clear: got ce=%b expected 00", bus.ce);
    end
    run_check(100);
  endtask

  task automatic test_loss();
    do_reset();
    load_inc(64'h8000_0000, 64'h3000_0000);
    go_run();
    run_check(10);
    pll_locked = 1'b0;
    run_check(2);
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (bus.ready !== 1'b0 || bus.ce !== '0 || bus.lock_lost !== 1'b1 || bus.ce_toggle !== m_tgl) begin
        errors++;
        $display("FAIL loss edge %0d: got rdy=%b ce=%b lost=%b tgl=%b expected rdy=0 ce=00 lost=1 tgl=%b",
                 n, bus.ready, bus.ce, bus.lock_lost, bus.ce_toggle, m_tgl);
      end
    end
    go_run();
    run_check(20);
    checks++;
    if (bus.lock_lost !== 1'b1) begin
      errors++;
      $display("FAIL lock_lost sticky: got %b expected 1", bus.lock_lost);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.ce !== '0 || bus.ce_toggle !== '0 || bus.ready !== 1'b0 || bus.lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL mid-op reset: got ce=%b tgl=%b rdy=%b lost=%b expected all 0",
               bus.ce, bus.ce_toggle, bus.ready, bus.lock_lost);
    end
    // Active increments were cleared by rst, so a fresh RUN must produce no enables.
    for (int c = 0; c < NUM_CH; c++) m_inc[c] = 0;
    m_tgl = '0;
    go_run();
    run_check(20);
  endtask

`ifdef PLL_CE_LOSS_COUNT_EN
  task automatic test_loss_count();
    int exp_cnt;
    do_reset();
    checks++;
    if (bus.loss_count !== '0) begin
      errors++;
      $display("FAIL loss_count reset: got %0d expected 0", bus.loss_count);
    end
    go_run();
    for (int e = 1; e <= 5; e++) begin
      pll_locked = 1'b0;
      for (int n = 0; n < 4; n++) tick();
      exp_cnt = (e < (1 << CNT_W) - 1) ? e : (1 << CNT_W) - 1;
      checks++;
      if (int'(bus.loss_count) !== exp_cnt) begin
        errors++;
        $display("FAIL loss_count event %0d: got %0d expected %0d", e, bus.loss_count, exp_cnt);
      end
      go_run();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.loss_count !== '0) begin
      errors++;
      $display("FAIL loss_count after rst: got %0d expected 0", bus.loss_count);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    pll_locked   = 1'b0;
    bus.inc      = '0;
    bus.inc_load = 1'b0;
    bus.sync     = 1'b0;
    m_ce_cnt0    = 0;
    test_reset();
    test_lock_timing();
    test_glitch();
    test_rates();
    test_boundary();
    test_random();
    test_sync_load();
    test_loss();
`ifdef PLL_CE_LOSS_COUNT_EN
    test_loss_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
